// File: rtl/inv_sub_bytes.sv
// Combinational 16-byte AES inverse S-box: inverse affine map followed by the GF(2^8)
// multiplicative inverse (x^254).
module inv_sub_bytes (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0 and maps 0 to 0, as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    for (genvar k = 0; k < 16; k++) begin : g_byte
        assign data_o[8*k +: 8] = inv_sbox(data_i[8*k +: 8]);
    end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryption core: one inverse round per clock, round keys fetched
// from an external key store via rk_idx/rk.
module aes_decrypt_core #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);

    localparam logic [3:0] LastRk = 4'(NR);

    typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

    state_e       st_q, st_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] isr, isb, imc;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0]  a, x2, x4, x8;
        logic [7:0]  m9 [4];
        logic [7:0]  mb [4];
        logic [7:0]  md [4];
        logic [7:0]  me [4];
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            a     = col[31-8*i -: 8];
            x2    = xtime(a);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        res = 32'h0;
        for (int i = 0; i < 4; i++) begin
            res[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
        end
        return res;
    endfunction

    // Byte k sits at row k%4, column k/4; row r rotates right by r columns.
    for (genvar k = 0; k < 16; k++) begin : g_isr
        localparam int Row = k % 4;
        localparam int Src = Row + 4 * (((k / 4) - Row + 4) % 4);
        assign isr[127-8*k -: 8] = state_q[127-8*Src -: 8];
    end

    inv_sub_bytes u_inv_sub_bytes (
        .data_i (isr),
        .data_o (isb)
    );

    for (genvar c = 0; c < 4; c++) begin : g_imc
        assign imc[127-32*c -: 32] = inv_mix_col(isb[127-32*c -: 32] ^ rk[127-32*c -: 32]);
    end

    always_comb begin
        st_d      = st_q;
        rnd_d     = rnd_q;
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = 4'd0;
        unique case (st_q)
            StIdle: begin
                in_ready = 1'b1;
                rk_idx   = LastRk;
                if (in_valid) begin
                    state_d = ciphertext ^ rk;
                    rnd_d   = LastRk - 4'd1;
                    st_d    = StRound;
                end
            end
            StRound: begin
                rk_idx  = rnd_q;
                state_d = imc;
                rnd_d   = rnd_q - 4'd1;
                if (rnd_q == 4'd1) st_d = StFinal;
            end
            StFinal: begin
                state_d = isb ^ rk;
                st_d    = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) st_d = StIdle;
            end
            default: st_d = StIdle;
        endcase
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            rk_idx    = LastRk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= StIdle;
            rnd_q   <= 4'd0;
            state_q <= 128'h0;
        end else begin
            st_q    <= st_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

    assign busy      = (st_q != StIdle) && !rst;
    assign plaintext = state_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed bench for aes_decrypt_core: FIPS-197 vectors, backpressure, mid-block reset and a
// streaming run checked against a forward-encryption reference model.
module tb_aes_decrypt_core;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] ciphertext = '0;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] plaintext;
    logic         busy;

    logic [127:0] rks [0:10];
    logic [127:0] spt [8];
    logic [127:0] sct [8];
    int           errors = 0;
    int           checks = 0;
    int           edges;
    int           pulses;
    logic [43:0]  trace;

    always #5 clk = ~clk;

    // External key store: combinational lookup of the requested round key.
    assign rk = (rk_idx <= 4'd10) ? rks[rk_idx] : '0;

    aes_decrypt_core #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .rk_idx     (rk_idx),
        .rk         (rk),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] p;
        inv = 8'h00;
        for (int v = 1; v < 256; v++) begin
            p = 8'(v);
            if (gmul(b, p) == 8'h01) inv = p;
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox(tmp[23:16]) ^ rc, sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int j = 0; j <= 10; j++) rks[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s;
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        int           src;
        s = pt ^ rks[0];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) begin
                src = (k % 4) + 4 * (((k / 4) + (k % 4)) % 4);
                t[127-8*k -: 8] = sbox(s[127-8*src -: 8]);
            end
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127-32*c -: 8];
                    a1 = t[119-32*c -: 8];
                    a2 = t[111-32*c -: 8];
                    a3 = t[103-32*c -: 8];
                    t[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                         a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                                         a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                                         gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
                end
            end
            s = t ^ rks[r];
        end
        return s;
    endfunction

    // Offers one block, then records rk_idx per cycle until out_valid; edges counts the
    // accepting edge as the first.
    task automatic run_to_done(input logic [127:0] ct);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        in_valid   = 1'b1;
        ciphertext = ct;
        trace      = {40'h0, rk_idx};
        @(posedge clk);
        edges = 1;
        while (edges < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) break;
            trace = {trace[39:0], rk_idx};
            @(posedge clk);
            edges++;
        end
    endtask

    initial begin
        int acc;
        int outs;
        int cyc;
        int last_acc;
        int guard;

        // Reset behaviour
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rk_idx", rk_idx, 10);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_plaintext", plaintext, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        // FIPS-197 C.1
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        run_to_done(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("c1_latency", edges, 11);
        chk("c1_plaintext", plaintext, 128'h00112233445566778899aabbccddeeff);
        chk("c1_busy_done", busy, 1);
        chk("c1_rk_trace", trace, 44'ha9876543210);
        @(negedge clk);
        chk("c1_out_valid_drop", out_valid, 0);
        chk("c1_in_ready_back", in_ready, 1);

        // FIPS-197 App. B
        expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_to_done(128'h3925841d02dc09fbdc118597196a0b32);
        chk("b_latency", edges, 11);
        chk("b_plaintext", plaintext, 128'h3243f6a8885a308d313198a2e0370734);
        chk("b_rk_trace", trace, 44'ha9876543210);

        // Backpressure in DONE; in_valid offered meanwhile must be ignored
        out_ready = 1'b0;
        run_to_done(128'h3925841d02dc09fbdc118597196a0b32);
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'b1;
            ciphertext = {$urandom, $urandom, $urandom, $urandom};
            chk("bp_out_valid", out_valid, 1);
            chk("bp_plaintext", plaintext, 128'h3243f6a8885a308d313198a2e0370734);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_released", out_valid, 0);
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("bp_no_duplicate", pulses, 0);
        chk("bp_idle_busy", busy, 0);

        // Reset while rnd==5
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        in_valid   = 1'b1;
        ciphertext = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (rk_idx != 4'd5 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_rnd5_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_busy_cleared", busy, 0);
        chk("mid_in_ready", in_ready, 1);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("mid_no_out_valid", pulses, 0);
        run_to_done(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("mid_c1_latency", edges, 11);
        chk("mid_c1_plaintext", plaintext, 128'h00112233445566778899aabbccddeeff);
        @(negedge clk);

        // Streaming with a random key against the forward-encryption model
        expand_key({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 8; i++) begin
            spt[i] = {$urandom, $urandom, $urandom, $urandom};
            sct[i] = encrypt(spt[i]);
        end
        acc = 0;
        outs = 0;
        cyc = 0;
        last_acc = 0;
        while (outs < 8 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                chk($sformatf("stream_pt%0d", outs), plaintext, spt[outs]);
                outs++;
            end
            if (acc < 8) begin
                in_valid   = 1'b1;
                ciphertext = sct[acc];
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                if (acc > 0) chk("stream_gap", cyc - last_acc, 12);
                last_acc = cyc;
                acc++;
            end
        end
        in_valid = 1'b0;
        chk("stream_accepts", acc, 8);
        chk("stream_outputs", outs, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_core.md
AES_DECRYPT_CORE -- requirements
Module: aes_decrypt_core

Interface
REQ-001 The module SHALL have a parameter NR, default 10, giving the number of AES rounds (AES-128); no other value is supported.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port rst, input, 1: reset, synchronous, active-high.
REQ-004 Port in_valid, input, 1: ciphertext offered.
REQ-005 Port in_ready, output, 1: core accepts ciphertext this cycle.
REQ-006 Port ciphertext, input, 128: block to decrypt; bits [127:120] = byte 0 (FIPS-197 column-major order).
REQ-007 Port rk_idx, output, 4: index of the round key the core needs this cycle.
REQ-008 Port rk, input, 128: round key for rk_idx, supplied combinationally in the same cycle by the external key store; same byte order as ciphertext.
REQ-009 Port out_valid, output, 1: plaintext available.
REQ-010 Port out_ready, input, 1: downstream accepts plaintext.
REQ-011 Port plaintext, output, 128: decrypted block; same byte order as ciphertext.
REQ-012 Port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-013 The core SHALL implement a 4-state FSM: IDLE, ROUND, FINAL, DONE, with a 4-bit round counter rnd and a 128-bit state register.
REQ-014 IDLE: in_ready = 1; rk_idx = 10; when in_valid=1, state <= ciphertext ^ rk, rnd <= 9, next state ROUND.
REQ-015 ROUND: rk_idx = rnd; state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk); rnd <= rnd-1; when rnd==1, next state FINAL, otherwise remain in ROUND.
REQ-016 FINAL: rk_idx = 0; state <= InvSubBytes(InvShiftRows(state)) ^ rk; next state DONE.
REQ-017 DONE: out_valid = 1; rk_idx = 0; plaintext = state; when out_ready=1, next state IDLE; otherwise hold state, plaintext and out_valid stable.
REQ-018 in_ready SHALL be 0 in ROUND, FINAL and DONE, and 0 while rst=1; in_valid is ignored outside IDLE.
REQ-019 Latency: out_valid SHALL rise exactly 11 clock edges after the accepting edge (1 load + 9 ROUND + 1 FINAL).
REQ-020 Throughput: with out_ready held at 1, consecutive accepts SHALL be 12 cycles apart.
REQ-021 InvShiftRows: byte at row r, column c moves to column (c+r) mod 4 (cyclic right rotation of row r by r positions).
REQ-022 InvSubBytes: implemented by instantiating the team's combinational inv_sub_bytes (16-byte inverse S-box) on the InvShiftRows output.
REQ-023 InvMixColumns: each column is multiplied by the circulant matrix {0e,0b,0d,09} over GF(2^8) with reduction polynomial 0x11B; implemented internally as xtime chains with no multipliers.
REQ-024 The data path SHALL be a single combinational round per cycle between state-register stages; there are no additional pipeline registers.
REQ-025 plaintext SHALL be driven from the state register in all states, and its value is meaningful only while out_valid=1.
REQ-026 The rk_idx sequence for one block SHALL be 10, 9, 8, ..., 1, 0, with each value presented in the cycle it is consumed.

Reset
REQ-027 While rst=1 at a clock edge: FSM <= IDLE, rnd <= 0, state <= 0; out_valid = 0, busy = 0, plaintext = 0, rk_idx = 10.
REQ-028 rst asserted in any state, including mid-ROUND or DONE, SHALL discard the block in flight; no out_valid pulse follows.
REQ-029 in_ready SHALL first be 1 in the cycle after rst deasserts.

Verification
REQ-030 Run FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, bench model serves rk -> plaintext 00112233445566778899aabbccddeeff, out_valid 11 edges after accept.
REQ-031 Run FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734; check the rk_idx trace is 10..0.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and plaintext stay stable and in_ready stays 0; releasing out_ready completes the transfer with no duplicate output.
REQ-033 Reset mid-operation: assert rst for 1 cycle when rnd==5 -> no out_valid pulse; a subsequent App. C.1 block decrypts correctly.
REQ-034 Streaming: 8 random blocks with in_valid always high and out_ready always 1 -> all outputs match the reference model in order, with accepts 12 cycles apart.
